// File: rtl/flash_pkg.sv
// Shared types and constants for the flash read responder.
package flash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } flash_state_t;

  // Worst-case cycles from accepting edge to data_valid
  localparam int FLASH_LATENCY_MAX = 10;
  localparam int FLASH_WORD_W      = 16;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and programmable rollover.
// The count runs 0 (after clear) up to rollover_val, then wraps to 1.
// rollover_flag is combinational: high when the current edge (with
// count_enable set) lands the count on rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;

  // Next-count selection: clear wins, then enabled increment with wrap
  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = NUM_CNT_BITS'(1);
      end else begin
        next_count = count_out + NUM_CNT_BITS'(1);
      end
    end
  end

  assign rollover_flag = count_enable && !clear && (next_count == rollover_val);

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
    end else begin
      count_out <= next_count;
    end
  end

endmodule

// File: rtl/flash_read_responder.sv
// Flash read responder: accepts a single-cycle read request, drives an
// asynchronous parallel NOR flash (CE/OE/address), waits WAIT_CYCLES with
// OE asserted, then registers the word onto flashData_out with a one-cycle
// data_valid pulse. Requests arriving while busy are dropped.
// Optional one-entry read cache enabled by defining FLASH_CACHE_EN.
module flash_read_responder
  import flash_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flash_ready,
  input  logic [ADDR_W-1:0]       flash_address,
  output logic [FLASH_WORD_W-1:0] flashData_out,
  output logic                    data_valid,
  output logic                    busy,
  output logic [ADDR_W-1:0]       fl_addr,
  output logic                    fl_ce_n,
  output logic                    fl_oe_n,
  input  logic [FLASH_WORD_W-1:0] fl_data
);

  flash_state_t state;

  logic       wait_clear;
  logic       wait_enable;
  logic       wait_last;
  logic [3:0] unused_wait_count;

`ifdef FLASH_CACHE_EN
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_valid;
  logic              cache_hit;

  assign cache_hit = cache_valid && (flash_address == cache_addr);
`endif

  assign busy        = (state != IDLE);
  assign wait_clear  = (state == SETUP);
  assign wait_enable = (state == WAIT);

  // Counts OE-low cycles; wait_last fires on the edge ending the final WAIT cycle
  flex_counter #(
    .NUM_CNT_BITS (4)
  ) u_wait_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (wait_clear),
    .count_enable  (wait_enable),
    .rollover_val  (4'(WAIT_CYCLES)),
    .count_out     (unused_wait_count),
    .rollover_flag (wait_last)
  );

  // Access sequencer with registered flash strobes, capture and valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      flashData_out <= '0;
      data_valid    <= 1'b0;
      fl_addr       <= '0;
      fl_ce_n       <= 1'b1;
      fl_oe_n       <= 1'b1;
`ifdef FLASH_CACHE_EN
      cache_addr    <= '0;
      cache_valid   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (flash_ready) begin
            fl_addr <= flash_address;
`ifdef FLASH_CACHE_EN
            if (cache_hit) begin
              // Hit: flashData_out already holds this word, skip the flash
              state      <= DONE;
              data_valid <= 1'b1;
            end else begin
              state   <= SETUP;
              fl_ce_n <= 1'b0;
            end
`else
            state   <= SETUP;
            fl_ce_n <= 1'b0;
`endif
          end
        end
        SETUP: begin
          state   <= WAIT;
          fl_oe_n <= 1'b0;
        end
        WAIT: begin
          if (wait_last) begin
            flashData_out <= fl_data;
            data_valid    <= 1'b1;
            fl_ce_n       <= 1'b1;
            fl_oe_n       <= 1'b1;
            state         <= DONE;
`ifdef FLASH_CACHE_EN
            cache_addr    <= fl_addr;
            cache_valid   <= 1'b1;
`endif
          end
        end
        DONE: begin
          data_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_responder.sv
// Self-checking bench for flash_read_responder: directed scenarios plus
// randomized requests against a timeline model of each access.
module tb_flash_read_responder;

  localparam int W = 6;

  logic        clk;
  logic        rst;
  logic        flash_ready;
  logic [15:0] flash_address;
  logic [15:0] flashData_out;
  logic        data_valid;
  logic        busy;
  logic [15:0] fl_addr;
  logic        fl_ce_n;
  logic        fl_oe_n;
  logic [15:0] fl_data;

  logic [15:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: accept cycle, done phase, address and expected data
  int          cyc     = 0;
  int          s_cyc   = -1000;
  int          dphase  = 2 + W;
  int          dv_seen = 0;
  logic        m_hit   = 1'b0;
  logic [15:0] m_addr  = '0;
  logic [15:0] m_data  = '0;
`ifdef FLASH_CACHE_EN
  logic        c_valid = 1'b0;
  logic [15:0] c_addr  = '0;
`endif

  flash_read_responder #(
    .ADDR_W      (16),
    .WAIT_CYCLES (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flash_ready   (flash_ready),
    .flash_address (flash_address),
    .flashData_out (flashData_out),
    .data_valid    (data_valid),
    .busy          (busy),
    .fl_addr       (fl_addr),
    .fl_ce_n       (fl_ce_n),
    .fl_oe_n       (fl_oe_n),
    .fl_data       (fl_data)
  );

  // Flash device: drives its word only while both enables are low
  assign fl_data = (!fl_ce_n && !fl_oe_n) ? mem[fl_addr] : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: apply inputs, advance the model, compare all outputs
  task automatic cycle(input logic rdy, input logic [15:0] addr);
    int ph;
    flash_ready   = rdy;
    flash_address = addr;
    ph = cyc - s_cyc;
    if (rdy && !(ph >= 1 && ph <= dphase)) begin
      s_cyc  = cyc;
      m_addr = addr;
      m_hit  = 1'b0;
`ifdef FLASH_CACHE_EN
      m_hit  = c_valid && (addr == c_addr);
`endif
      dphase = m_hit ? 1 : 2 + W;
    end
    @(posedge clk);
    #1;
    cyc++;
    ph = cyc - s_cyc;
    if (ph == dphase && !m_hit) begin
      m_data = mem[m_addr];
`ifdef FLASH_CACHE_EN
      c_valid = 1'b1;
      c_addr  = m_addr;
`endif
    end
    if (data_valid) dv_seen++;
    chk("data_valid", data_valid, ph == dphase);
    chk("busy", busy, ph >= 1 && ph <= dphase);
    chk("fl_ce_n", fl_ce_n, !(!m_hit && ph >= 1 && ph <= 1 + W));
    chk("fl_oe_n", fl_oe_n, !(!m_hit && ph >= 2 && ph <= 1 + W));
    chk("fl_addr", fl_addr, m_addr);
    chk("flashData_out", flashData_out, m_data);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 16'($urandom));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst         = 1'b1;
    flash_ready = 1'b0;
    #1;
    chk("rst_ce_n", fl_ce_n, 1'b1);
    chk("rst_oe_n", fl_oe_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_data", flashData_out, 16'h0000);
    chk("rst_addr", fl_addr, 16'h0000);
    s_cyc  = -1000;
    m_hit  = 1'b0;
    m_addr = '0;
    m_data = '0;
`ifdef FLASH_CACHE_EN
    c_valid = 1'b0;
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    logic [15:0] last_addr;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    rst           = 1'b0;
    flash_ready   = 1'b0;
    flash_address = '0;
    #2;
    do_reset();

    // Single read at 0x0003
    mem[16'h0003] = 16'hA5C3;
    cycle(1'b1, 16'h0003);
    idle(10);
    chk("t1_data", flashData_out, 16'hA5C3);
    chk("t1_addr", fl_addr, 16'h0003);

    // Request while busy is dropped
    mem[16'h0010] = 16'h5151;
    dv_seen = 0;
    cycle(1'b1, 16'h0010);
    cycle(1'b0, 16'h0011);
    cycle(1'b1, 16'h0011);
    idle(12);
    chk("drop_dv_count", dv_seen, 1);
    chk("drop_addr", fl_addr, 16'h0010);

    // Back-to-back requests 11 cycles apart
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'hBEEF;
    cycle(1'b1, 16'h0000);
    idle(10);
    chk("b2b_first", flashData_out, 16'h1234);
    cycle(1'b1, 16'h0001);
    idle(6);
    chk("b2b_hold", flashData_out, 16'h1234);
    idle(4);
    chk("b2b_second", flashData_out, 16'hBEEF);

    // Reset in the fourth WAIT cycle aborts the access
    cycle(1'b1, 16'h0042);
    idle(4);
    chk("abort_oe_low", fl_oe_n, 1'b0);
    do_reset();
    dv_seen = 0;
    idle(12);
    chk("abort_no_dv", dv_seen, 0);

    // Top of address space
    mem[16'hFFFF] = 16'h0F0F;
    cycle(1'b1, 16'hFFFF);
    idle(10);
    chk("wrap_addr", fl_addr, 16'hFFFF);
    chk("wrap_data", flashData_out, 16'h0F0F);

`ifdef FLASH_CACHE_EN
    // Cache hit returns stored word without touching the flash
    mem[16'h0020] = 16'h7777;
    cycle(1'b1, 16'h0020);
    idle(10);
    mem[16'h0020] = 16'h0000;
    cycle(1'b1, 16'h0020);
    chk("hit_dv", data_valid, 1'b1);
    chk("hit_ce_n", fl_ce_n, 1'b1);
    chk("hit_data", flashData_out, 16'h7777);
    idle(3);
    mem[16'h0021] = 16'h2121;
    cycle(1'b1, 16'h0021);
    idle(6);
    chk("miss_no_dv_yet", data_valid, 1'b0);
    idle(1);
    chk("miss_dv", data_valid, 1'b1);
    chk("miss_data", flashData_out, 16'h2121);
    idle(3);
`endif

    // Randomized requests, often repeating the previous address
    last_addr = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      logic        rdy;
      logic [15:0] a;
      rdy = ($urandom_range(0, 3) == 0);
      a   = ($urandom_range(0, 1) == 0) ? last_addr : 16'($urandom);
      if (rdy) last_addr = a;
      cycle(rdy, a);
    end
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flash_read_responder.md
Name: flash_read_responder

Overview:
- Memory-side responder for the network controller's flash read interface.
- Accepts a single-cycle `flash_ready` request with a 16-bit `flash_address`.
- Drives an external asynchronous parallel NOR flash (chip enable, output enable, address), waits a fixed number of access cycles, then registers the 16-bit word onto `flashData_out`.
- Total latency is fixed and bounded, so a requester that samples 11 cycles after its request always sees valid data.

Parameters:
- ADDR_W, 16, width of request address and external flash address bus.
- WAIT_CYCLES, 6, cycles `fl_oe_n` is held low before data capture; legal range 1..8 (2+WAIT_CYCLES must be ≤ 10).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flash_ready  in  1  read request strobe from network controller
- flash_address  in  ADDR_W  word address, sampled on accepting edge
- flashData_out  out  16  registered read data, held until next capture
- data_valid  out  1  one-cycle pulse: `flashData_out` updated/valid this cycle
- busy  out  1  high while a request is in flight (SETUP, WAIT, DONE)
- fl_addr  out  ADDR_W  registered address to external flash
- fl_ce_n  out  1  external chip enable, active-low
- fl_oe_n  out  1  external output enable, active-low
- fl_data  in  16  external flash data bus

Behaviour:
- Reset (async, immediate): state=IDLE, `flashData_out`=0, `data_valid`=0, `busy`=0, `fl_addr`=0, `fl_ce_n`=1, `fl_oe_n`=1, wait count=0. Reset mid-access aborts with no capture and no `data_valid`.
- States: IDLE, SETUP, WAIT, DONE.
- IDLE:
  - `fl_ce_n`=1, `fl_oe_n`=1.
  - On an edge with `flash_ready`=1: latch `flash_address` into `fl_addr` and go to SETUP.
- SETUP (1 cycle): `fl_ce_n`=0, `fl_oe_n`=1, address stable; go to WAIT with wait counter cleared.
- WAIT (exactly WAIT_CYCLES cycles):
  - `fl_ce_n`=0, `fl_oe_n`=0.
  - On the edge ending the last WAIT cycle, register `fl_data` into `flashData_out` and go to DONE.
- DONE (1 cycle): `data_valid`=1, `fl_ce_n`=1, `fl_oe_n`=1; go to IDLE unconditionally.
- Latency: accepting edge E0; SETUP is cycle 1, WAIT is cycles 2..1+WAIT_CYCLES, DONE is cycle 2+WAIT_CYCLES (8 at default).
- `busy`: combinational, high in SETUP/WAIT/DONE.
- `flash_ready` while busy: ignored. The request is dropped, not queued, and `fl_addr` is unchanged.
- `flash_address` is sampled only on the accepting edge. Later changes (e.g. requester post-increment) have no effect on the access in flight.
- `fl_addr` holds its last value in IDLE. `flashData_out` holds its value between captures.
- Address wrap: no arithmetic is performed; 0xFFFF is accessed like any other address.

Optional Feature:
- Macro: FLASH_CACHE_EN.
- Defined:
  - One-entry read cache (`cache_addr`, `cache_valid`); `cache_valid`=0 on reset.
  - Each external capture sets `cache_addr`=`fl_addr` and `cache_valid`=1.
  - Accepted request with `cache_valid`=1 and `flash_address`==`cache_addr` goes IDLE→DONE directly. `data_valid` is asserted in cycle 1, `flashData_out` is unchanged, and `fl_ce_n`/`fl_oe_n` stay 1.
  - A miss behaves as the base access.
- Undefined: every request performs the full external access; no cache storage exists.

Decomposition:
- Shared package flash_pkg:
  - enum type `flash_state_t` {IDLE, SETUP, WAIT, DONE}
  - constant FLASH_LATENCY_MAX=10
  - constant FLASH_WORD_W=16
- Wait counting uses one instance of the existing flex_counter (NUM_CNT_BITS=4, rollover_val=WAIT_CYCLES, clear asserted in SETUP). No other sub-module.

Test Plan:
- Reset then single request, `flash_address`=0x0003, `fl_data` model returns 0xA5C3 → `fl_addr`=0x0003, `fl_ce_n` low cycles 1-7, `fl_oe_n` low cycles 2-7, `data_valid` pulse in cycle 8, `flashData_out`=0xA5C3.
- Request at 0x0010, second `flash_ready` pulse at cycle 3 with address 0x0011 → second request dropped, `fl_addr` stays 0x0010, exactly one `data_valid`.
- Back-to-back requests 11 cycles apart at 0x0000 then 0x0001, data 0x1234/0xBEEF → each `data_valid` at +8 with correct data. `flashData_out` holds 0x1234 until the second capture.
- Assert `rst` in WAIT cycle 4 → `fl_ce_n`/`fl_oe_n` go to 1 immediately, `busy`=0, `flashData_out`=0, no `data_valid` after release.
- Address 0xFFFF with `fl_data`=0x0F0F → `fl_addr`=0xFFFF and `flashData_out`=0x0F0F, no wrap side effects.
- FLASH_CACHE_EN defined:
  - Read 0x0020 (data 0x7777), then re-request 0x0020 → `data_valid` in cycle 1, `fl_ce_n` stays 1, data 0x7777.
  - Then request 0x0021 → full 8-cycle access.
